// File: rtl/rom_loader.sv
// rom_loader: strips an optional copier header from the ioctl word stream and queues words to SDRAM
module rom_loader #(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 24
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              ioctl_download,
    input  logic              ioctl_wr,
    input  logic [24:0]       ioctl_addr,
    input  logic [15:0]       ioctl_dout,
    input  logic [23:0]       ioctl_filesize,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_din,
    input  logic              mem_ack,
    output logic              rom_loaded,
    output logic [ADDR_W-1:0] rom_mask,
    output logic              overflow
);
    localparam int PW = $clog2(FIFO_DEPTH);
    typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;
    state_t state;
    logic [ADDR_W+15:0] fifo [FIFO_DEPTH];
    logic [PW-1:0] rd, wr;
    logic [PW:0] count;
    logic dl_q, hdr, rise, fall, pop, push, accept, full;
    logic [ADDR_W:0] size, eff2, size_m1;
    logic [ADDR_W-1:0] eff, smear;
    logic unused;
    assign unused = ^{ioctl_filesize[23:10], size_m1[ADDR_W]};
    // Edge detection, FIFO handshake decode, effective address and mask smear
    always_comb begin
        rise = ioctl_download & ~dl_q;
        fall = ~ioctl_download & dl_q;
        mem_req = count != '0;
        pop = mem_ack & mem_req;
        full = count == (PW+1)'(FIFO_DEPTH);
        push = state == LOAD && ioctl_wr && !(hdr && ioctl_addr < 25'd512);
        accept = push && (!full || pop);
        eff = ADDR_W'(ioctl_addr - (hdr ? 25'd512 : 25'd0));
        eff2 = {1'b0, eff} + (ADDR_W+1)'(2);
        size_m1 = size - (ADDR_W+1)'(1);
        smear = size_m1[ADDR_W-1:0];
        for (int i = 1; i < ADDR_W; i++) smear = smear | (smear >> 1);
        mem_addr = mem_req ? fifo[rd][ADDR_W+15:16] : '0;
        mem_din = mem_req ? fifo[rd][15:0] : '0;
    end
    // Word storage; a slot is only written when it is free or being popped this cycle
    always_ff @(posedge clk_sys) begin
        if (accept) fifo[wr] <= {eff, ioctl_dout};
    end
    // Load FSM, FIFO pointers and registered status outputs
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state <= IDLE;
            rd <= '0;
            wr <= '0;
            count <= '0;
            dl_q <= 1'b0;
            hdr <= 1'b0;
            size <= '0;
            rom_loaded <= 1'b0;
            rom_mask <= '0;
            overflow <= 1'b0;
        end else begin
            dl_q <= ioctl_download;
            if (rise) begin
                state <= LOAD;
                hdr <= ioctl_filesize[9:0] == 10'd512;
                size <= '0;
                rom_loaded <= 1'b0;
                overflow <= 1'b0;
                rd <= rd + PW'(pop);
                wr <= rd + PW'(mem_req);
                count <= (PW+1)'(mem_req && !pop);
            end else begin
                rd <= rd + PW'(pop);
                wr <= wr + PW'(accept);
                count <= count + (PW+1)'(accept) - (PW+1)'(pop);
                if (push && full && !pop) overflow <= 1'b1;
                if (accept && eff2 > size) size <= eff2;
                if (state == LOAD && fall) state <= DRAIN;
                if (state == DRAIN && !mem_req) begin
                    state <= DONE;
                    rom_loaded <= 1'b1;
                    rom_mask <= (size == '0) ? '0 : smear;
                end
            end
        end
    end
endmodule

// File: tb/tb_rom_loader.sv
// tb_rom_loader: random and directed downloads checked every cycle against a queue-based model
module tb_rom_loader;
    localparam int AW = 24;
    logic clk_sys = 0, reset = 1, ioctl_download = 0, ioctl_wr = 0, mem_ack = 0;
    logic [24:0] ioctl_addr = 0;
    logic [15:0] ioctl_dout = 0;
    logic [23:0] ioctl_filesize = 0;
    logic mem_req, rom_loaded, overflow;
    logic [AW-1:0] mem_addr, rom_mask;
    logic [15:0] mem_din;
    int checks = 0, errors = 0, ack_prob = 100, n_wr = 0, n0;
    bit run = 0;
    logic [AW-1:0] last_addr = 0;

    always #5 clk_sys = ~clk_sys;

    rom_loader #(.FIFO_DEPTH(4), .ADDR_W(AW)) dut (
        .clk_sys(clk_sys), .reset(reset), .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
        .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_filesize(ioctl_filesize),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_din(mem_din), .mem_ack(mem_ack),
        .rom_loaded(rom_loaded), .rom_mask(rom_mask), .overflow(overflow)
    );

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
        end
    endtask

    // Behavioural model: the write queue holds every word still owed to SDRAM
    typedef struct {int a; logic [15:0] d;} ent_t;
    ent_t q[$];
    bit m_loading = 0, m_draining = 0, m_hdr = 0, m_loaded = 0, m_ov = 0, m_prev = 0;
    int m_size = 0, m_mask = 0;

    always @(posedge clk_sys) begin
        int pre, eff, p;
        bit pop, rise, fall;
        if (reset) begin
            q.delete();
            m_loading = 0; m_draining = 0; m_loaded = 0; m_mask = 0;
            m_ov = 0; m_size = 0; m_prev = 0; m_hdr = 0;
        end else begin
            pre = q.size();
            pop = mem_ack && pre > 0;
            rise = ioctl_download && !m_prev;
            fall = !ioctl_download && m_prev;
            if (rise) begin
                if (pop || pre == 0) q.delete();
                else while (q.size() > 1) void'(q.pop_back());
                m_hdr = ioctl_filesize[9:0] == 10'd512;
                m_size = 0; m_loaded = 0; m_ov = 0; m_loading = 1; m_draining = 0;
            end else begin
                if (pop) void'(q.pop_front());
                if (m_loading && ioctl_wr && !(m_hdr && ioctl_addr < 512)) begin
                    eff = (int'(ioctl_addr) - (m_hdr ? 512 : 0)) & 'hFFFFFF;
                    if (q.size() < 4) begin
                        q.push_back('{eff, ioctl_dout});
                        if (eff + 2 > m_size) m_size = eff + 2;
                    end else m_ov = 1;
                end
                if (m_loading && fall) begin
                    m_loading = 0; m_draining = 1;
                end else if (m_draining && pre == 0) begin
                    m_draining = 0; m_loaded = 1;
                    p = 1;
                    while (p < m_size) p *= 2;
                    m_mask = m_size == 0 ? 0 : p - 1;
                end
            end
            m_prev = ioctl_download;
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk_sys) if (run) begin
        chk("mem_req", mem_req, q.size() != 0);
        chk("mem_addr", mem_addr, q.size() != 0 ? q[0].a : 0);
        chk("mem_din", mem_din, q.size() != 0 ? q[0].d : 0);
        chk("rom_loaded", rom_loaded, m_loaded);
        chk("rom_mask", rom_mask, m_mask);
        chk("overflow", overflow, m_ov);
    end

    // Committed SDRAM writes as seen on the port
    always @(posedge clk_sys) if (!reset && mem_req && mem_ack) begin
        n_wr++;
        last_addr = mem_addr;
    end

    task automatic step(input bit w, input logic [24:0] a, input logic [15:0] d, input int ak);
        @(negedge clk_sys);
        ioctl_wr = w; ioctl_addr = a; ioctl_dout = d;
        mem_ack = ak >= 0 ? ak[0] : ($urandom_range(99) < ack_prob);
    endtask

    task automatic start(input logic [23:0] fs);
        ioctl_filesize = fs;
        step(0, 0, 0, -1);
        ioctl_download = 1;
        step(0, 0, 0, -1);
        n0 = n_wr;
    endtask

    task automatic finish_dl();
        int t = 0;
        ioctl_download = 0;
        ack_prob = 100;
        while (!rom_loaded && t < 2000) begin
            step(0, 0, 0, -1);
            t++;
        end
        chk("done_reached", rom_loaded, 1);
    endtask

    initial begin
        repeat (2) @(negedge clk_sys);
        run = 1;
        chk("rst_req", mem_req, 0);
        chk("rst_loaded", rom_loaded, 0);
        chk("rst_mask", rom_mask, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_addr", mem_addr, 0);
        reset = 0;
        // plain 1 KiB image
        start(1024);
        for (int i = 0; i < 512; i++) begin
            step(1, 25'(i * 2), 16'($urandom), -1);
            step(0, 0, 0, -1);
        end
        finish_dl();
        chk("t1_count", n_wr - n0, 512);
        chk("t1_last", last_addr, 'h3FE);
        chk("t1_mask", rom_mask, 'h3FF);
        chk("t1_ovf", overflow, 0);
        // image behind a 512-byte copier header
        start(1536);
        for (int i = 0; i < 768; i++) begin
            step(1, 25'(i * 2), 16'($urandom), -1);
            step(0, 0, 0, -1);
        end
        finish_dl();
        chk("t2_count", n_wr - n0, 512);
        chk("t2_last", last_addr, 'h3FE);
        chk("t2_mask", rom_mask, 'h3FF);
        // SDRAM stalled: fifth word dropped
        start(10);
        for (int i = 0; i < 5; i++) step(1, 25'(i * 2), 16'($urandom), 0);
        step(0, 0, 0, 0);
        chk("t3_ovf", overflow, 1);
        chk("t3_req", mem_req, 1);
        chk("t3_head", mem_addr, 0);
        finish_dl();
        chk("t3_count", n_wr - n0, 4);
        chk("t3_mask", rom_mask, 'h7);
        chk("t3_ovf_sticky", overflow, 1);
        // large sparse image, no header
        start(24'h300000);
        step(1, 0, 16'h1111, -1);
        step(0, 0, 0, -1);
        step(1, 25'h100000, 16'h2222, -1);
        step(0, 0, 0, -1);
        step(1, 25'h2FFFFE, 16'h3333, -1);
        finish_dl();
        chk("t4_last", last_addr, 'h2FFFFE);
        chk("t4_mask", rom_mask, 'h3FFFFF);
        // push coincident with pop while full
        start(20);
        for (int i = 0; i < 4; i++) step(1, 25'(i * 2), 16'($urandom), 0);
        step(1, 8, 16'hABCD, 1);
        step(0, 0, 0, 0);
        chk("t5_ovf", overflow, 0);
        chk("t5_req", mem_req, 1);
        finish_dl();
        chk("t5_count", n_wr - n0, 5);
        chk("t5_mask", rom_mask, 'hF);
        // reset in the middle of a pending request
        start(64);
        step(1, 0, 16'h5555, 0);
        step(1, 2, 16'h6666, 0);
        step(0, 0, 0, 0);
        chk("t6_req_before", mem_req, 1);
        reset = 1;
        ioctl_download = 0;
        step(0, 0, 0, 0);
        chk("t6_req", mem_req, 0);
        chk("t6_loaded", rom_loaded, 0);
        chk("t6_mask", rom_mask, 0);
        reset = 0;
        start(4);
        step(1, 0, 16'h7777, 0);
        step(0, 0, 0, 0);
        chk("t6_first_req", mem_req, 1);
        chk("t6_first_addr", mem_addr, 0);
        chk("t6_first_din", mem_din, 'h7777);
        step(1, 2, 16'h8888, -1);
        finish_dl();
        chk("t6_count", n_wr - n0, 2);
        chk("t6_mask2", rom_mask, 'h3);
        // randomized downloads
        for (int k = 0; k < 10; k++) begin
            bit h;
            int nw, base;
            h = 1'($urandom_range(1));
            nw = $urandom_range(4, 40);
            base = h ? 512 - 2 * $urandom_range(0, 8) : 0;
            start(h ? 24'd1536 : 24'(nw * 2));
            ack_prob = $urandom_range(10, 100);
            for (int i = 0; i < nw; i++) begin
                step(1, 25'(base + 2 * i), 16'($urandom), -1);
                repeat ($urandom_range(0, 2)) step(0, 0, 0, -1);
            end
            ioctl_download = 0;
            step(1, 25'(2 * $urandom_range(0, 100)), 16'($urandom), -1);
            finish_dl();
            step(1, 25'h40, 16'hDEAD, -1);
        end
        step(0, 0, 0, -1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
